// File: rtl/c2c_r_arb.sv
// Two-to-one read arbiter: loads beat fetches, a starvation counter forces a fetch grant after STARVE_LIMIT load grants.
// Latency: request seen in IDLE -> m_re next cycle, acks/data combinational; backpressure: requesters hold re until their ack.
module c2c_r_arb #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_re,
    input  logic [XLEN-1:0] i_addr,
    output logic [XLEN-1:0] i_data,
    output logic            i_ack,
    input  logic            d_re,
    input  logic [XLEN-1:0] d_addr,
    output logic [XLEN-1:0] d_data,
    output logic            d_ack,
    output logic            m_re,
    output logic [XLEN-1:0] m_addr,
    input  logic [XLEN-1:0] m_data,
    input  logic            m_ack,
    output logic [1:0]      owner,
    output logic            err_stray_ack
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] scnt;
    logic          starve;

    assign starve = i_re && (scnt == SLIM);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_re && !starve) begin
                    state_nxt = GNT_D;
                end else if (i_re) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (m_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            scnt          <= '0;
            err_stray_ack <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && m_ack) begin
                err_stray_ack <= 1'b1;
            end
            // Only loads granted over a waiting fetch count toward starvation.
            if (state == IDLE && state_nxt == GNT_D) begin
                if (!i_re) begin
                    scnt <= '0;
                end else if (scnt != SLIM) begin
                    scnt <= scnt + SW'(1);
                end
            end else if (state == IDLE && state_nxt == GNT_I) begin
                scnt <= '0;
            end
        end
    end

    assign i_data = m_data;
    assign d_data = m_data;
    assign i_ack  = m_ack && (state == GNT_I);
    assign d_ack  = m_ack && (state == GNT_D);
    assign m_re   = (state != IDLE);

    always_comb begin
        m_addr = '0;
        owner  = 2'd0;
        case (state)
            GNT_I: begin
                m_addr = i_addr;
                owner  = 2'd1;
            end
            GNT_D: begin
                m_addr = d_addr;
                owner  = 2'd2;
            end
            default: begin
                m_addr = '0;
                owner  = 2'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_c2c_r_arb.sv
// Directed bench for c2c_r_arb: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_c2c_r_arb;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset_n;
    logic            i_re;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_data;
    logic            i_ack;
    logic            d_re;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_data;
    logic            d_ack;
    logic            m_re;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_data;
    logic            m_ack;
    logic [1:0]      owner;
    logic            err_stray_ack;

    int n_cmp = 0;
    int n_err = 0;

    c2c_r_arb #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_re          (i_re),
        .i_addr        (i_addr),
        .i_data        (i_data),
        .i_ack         (i_ack),
        .d_re          (d_re),
        .d_addr        (d_addr),
        .d_data        (d_data),
        .d_ack         (d_ack),
        .m_re          (m_re),
        .m_addr        (m_addr),
        .m_data        (m_data),
        .m_ack         (m_ack),
        .owner         (owner),
        .err_stray_ack (err_stray_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_re = 1'b0; d_re = 1'b0; m_ack = 1'b0;
        i_addr = '0; d_addr = '0; m_data = 32'h1234_5678;
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if ({m_re, owner, i_ack, d_ack, err_stray_ack} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got m_re=%b owner=%0d i_ack=%b d_ack=%b err=%b, want all 0",
                     m_re, owner, i_ack, d_ack, err_stray_ack);
        end
        n_cmp++;
        if (m_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_maddr: got %h want 0", m_addr);
        end
        n_cmp++;
        if (i_data !== 32'h1234_5678 || d_data !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL reset_data_bcast: got i=%h d=%h want 12345678", i_data, d_data);
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        i_re = 1'b1; i_addr = 32'h100;
        tick();
        @(negedge clk);
        n_cmp++;
        if (m_re !== 1'b1 || m_addr !== 32'h100 || owner !== 2'd1) begin
            n_err++;
            $display("FAIL fetch_grant: got m_re=%b m_addr=%h owner=%0d want 1/00000100/1", m_re, m_addr, owner);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (i_ack !== 1'b0 || m_re !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_wait: got i_ack=%b m_re=%b want 0/1", i_ack, m_re);
        end
        tick();
        m_ack = 1'b1; m_data = 32'hDEAD_BEEF; i_re = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (i_ack !== 1'b1 || i_data !== 32'hDEAD_BEEF || d_ack !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_ack: got i_ack=%b i_data=%h d_ack=%b want 1/deadbeef/0", i_ack, i_data, d_ack);
        end
        tick();
        m_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (owner !== 2'd0 || m_re !== 1'b0 || i_ack !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_done: got owner=%0d m_re=%b i_ack=%b want 0/0/0", owner, m_re, i_ack);
        end
    endtask

    task automatic test_collision();
        tick();
        i_re = 1'b1; i_addr = 32'h200;
        d_re = 1'b1; d_addr = 32'h300;
        tick();
        @(negedge clk);
        n_cmp++;
        if (m_addr !== 32'h300 || owner !== 2'd2) begin
            n_err++;
            $display("FAIL collide_first: got m_addr=%h owner=%0d want 00000300/2", m_addr, owner);
        end
        tick();
        m_ack = 1'b1; d_re = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_ack !== 1'b1 || i_ack !== 1'b0) begin
            n_err++;
            $display("FAIL collide_dack: got d_ack=%b i_ack=%b want 1/0", d_ack, i_ack);
        end
        tick();
        m_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_re !== 1'b0 || owner !== 2'd0) begin
            n_err++;
            $display("FAIL collide_idle: got m_re=%b owner=%0d want 0/0", m_re, owner);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (m_addr !== 32'h200 || owner !== 2'd1) begin
            n_err++;
            $display("FAIL collide_second: got m_addr=%h owner=%0d want 00000200/1", m_addr, owner);
        end
        tick();
        m_ack = 1'b1; i_re = 1'b0;
        tick();
        m_ack = 1'b0;
    endtask

    task automatic test_starvation();
        logic [1:0]      exp_owner;
        logic [XLEN-1:0] exp_addr;
        bit              found;
        i_re = 1'b1; i_addr = 32'h400;
        d_re = 1'b1; d_addr = 32'h1000;
        for (int g = 0; g < 10; g++) begin
            found = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (m_re === 1'b1) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            if (!found) begin
                n_cmp++;
                n_err++;
                $display("FAIL starve_timeout: grant %0d never arrived", g);
                break;
            end
            exp_owner = (g == 4 || g == 9) ? 2'd1 : 2'd2;
            exp_addr  = (exp_owner == 2'd1) ? 32'h400 : d_addr;
            n_cmp++;
            if (owner !== exp_owner || m_addr !== exp_addr) begin
                n_err++;
                $display("FAIL starve_seq: grant %0d got owner=%0d m_addr=%h want %0d/%h",
                         g, owner, m_addr, exp_owner, exp_addr);
            end
            m_ack = 1'b1;
            tick();
            m_ack = 1'b0;
            if (exp_owner == 2'd2) begin
                d_addr = d_addr + 32'h10;
            end
            if (g == 9) begin
                i_re = 1'b0; d_re = 1'b0;
            end
        end
        i_re = 1'b0; d_re = 1'b0; m_ack = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] pat;
        pat = 5'b10101;
        d_re = 1'b1; d_addr = 32'h500;
        for (int c = 0; c < 5; c++) begin
            tick();
            m_ack = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (m_re !== pat[c]) begin
                n_err++;
                $display("FAIL b2b_mre: cycle %0d got %b want %b", c, m_re, pat[c]);
            end
            m_ack = m_re;
            #1;
            n_cmp++;
            if (d_ack !== pat[c]) begin
                n_err++;
                $display("FAIL b2b_dack: cycle %0d got %b want %b", c, d_ack, pat[c]);
            end
            if (c == 4) d_re = 1'b0;
        end
        tick();
        m_ack = 1'b0;
    endtask

    task automatic test_drop();
        tick();
        d_re = 1'b1; d_addr = 32'h600;
        tick();
        d_re = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (m_re !== 1'b1 || m_addr !== 32'h600 || owner !== 2'd2) begin
            n_err++;
            $display("FAIL drop_hold: got m_re=%b m_addr=%h owner=%0d want 1/00000600/2", m_re, m_addr, owner);
        end
        tick();
        m_ack = 1'b1; m_data = 32'hCAFE_F00D;
        @(negedge clk);
        n_cmp++;
        if (d_ack !== 1'b1 || d_data !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL drop_ack: got d_ack=%b d_data=%h want 1/cafef00d", d_ack, d_data);
        end
        tick();
        m_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_re !== 1'b0 || err_stray_ack !== 1'b0) begin
            n_err++;
            $display("FAIL drop_done: got m_re=%b err=%b want 0/0", m_re, err_stray_ack);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        d_re = 1'b1; d_addr = 32'h700;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; d_re = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (owner !== 2'd0 || m_re !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_abandon: got owner=%0d m_re=%b want 0/0", owner, m_re);
        end
        tick();
        m_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_ack !== 1'b0 || i_ack !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_noack: got d_ack=%b i_ack=%b want 0/0", d_ack, i_ack);
        end
        tick();
        m_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err_stray_ack !== 1'b1) begin
            n_err++;
            $display("FAIL stray_set: got %b want 1", err_stray_ack);
        end
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (err_stray_ack !== 1'b1) begin
            n_err++;
            $display("FAIL stray_sticky: got %b want 1", err_stray_ack);
        end
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (err_stray_ack !== 1'b0) begin
            n_err++;
            $display("FAIL stray_clear: got %b want 0", err_stray_ack);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_collision();
        test_starvation();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
